// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter: one shift/add-3 step per clock,
// start/done handshake, optional two's-complement input with separate sign output.
module bcd_seq_conv #(
  parameter int W  = 32,
  parameter int ND = 10
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start_i,
  input  logic [W-1:0]    Bin_i,
  input  logic            Signed_i,
  output logic            Busy_o,
  output logic            Done_o,
  output logic [4*ND-1:0] Bcd_o,
  output logic            Neg_o,
  output logic            Ovf_o,
  output logic [1:0]      dbg_state
);

  // Handshake: Start_i is taken only on an edge where Busy_o=0 (IDLE); Bin_i and
  // Signed_i are sampled on that same edge. Done_o pulses for exactly one cycle,
  // which is also the first IDLE cycle, so a new Start_i may be accepted right away.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CW = $clog2(W + 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      mag;
  logic              neg_q;
  logic              ovf_q;
  logic [4*ND-1:0]   scratch;
  logic [4*ND-1:0]   scratch_adj;
  logic              accept;
  logic              last_shift;
  logic              in_neg;

  assign accept     = (state == S_IDLE) && Start_i;
  assign last_shift = (cnt == CW'(W - 1));
  assign in_neg     = Signed_i & Bin_i[W-1];

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Start_i) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (last_shift) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy_o    = (state != S_IDLE);
    dbg_state = state;
  end

  // Add-3 correction applied to every digit before it is doubled by the shift
  always_comb begin
    scratch_adj = '0;
    for (int i = 0; i < ND; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end else begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4];
      end
    end
  end

  // Datapath: operand capture, shift sequence, and result registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mag     <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      scratch <= '0;
      cnt     <= '0;
      Done_o  <= 1'b0;
      Bcd_o   <= '0;
      Neg_o   <= 1'b0;
      Ovf_o   <= 1'b0;
    end else begin
      Done_o <= (state == S_DONE);
      if (accept) begin
        // -2^(W-1) negates to 2^(W-1), which still fits W unsigned bits
        neg_q <= in_neg;
        mag   <= in_neg ? (~Bin_i + W'(1)) : Bin_i;
      end
      case (state)
        S_LOAD: begin
          scratch <= '0;
          cnt     <= '0;
          ovf_q   <= 1'b0;
        end
        S_SHIFT: begin
          scratch <= {scratch_adj[4*ND-2:0], mag[W-1]};
          mag     <= {mag[W-2:0], 1'b0};
          ovf_q   <= ovf_q | scratch_adj[4*ND-1];
          cnt     <= cnt + CW'(1);
        end
        S_DONE: begin
          Bcd_o <= scratch;
          Neg_o <= neg_q;
          Ovf_o <= ovf_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: a 10-digit and a 6-digit instance, arithmetic reference model,
// expected-result queue, latency/busy/hold checks, ignored starts and mid-run reset.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] bin;
  logic        sgn;

  logic        busy_a, done_a, neg_a, ovf_a;
  logic [39:0] bcd_a;
  logic [1:0]  state_a;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [23:0] bcd_b;
  logic [1:0]  state_b;

  logic [41:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_seq_conv #(.W(32), .ND(10)) u_dut (
    .Clk(clk), .Rst(rst), .Start_i(start_a), .Bin_i(bin), .Signed_i(sgn),
    .Busy_o(busy_a), .Done_o(done_a), .Bcd_o(bcd_a), .Neg_o(neg_a), .Ovf_o(ovf_a),
    .dbg_state(state_a)
  );

  bcd_seq_conv #(.W(32), .ND(6)) u_dut6 (
    .Clk(clk), .Rst(rst), .Start_i(start_b), .Bin_i(bin), .Signed_i(sgn),
    .Busy_o(busy_b), .Done_o(done_b), .Bcd_o(bcd_b), .Neg_o(neg_b), .Ovf_o(ovf_b),
    .dbg_state(state_b)
  );

  // Reference: decimal digits by division; result packed as {neg, ovf, bcd[39:0]}
  function automatic logic [41:0] model(input logic [31:0] b, input logic s, input int nd);
    logic              neg;
    logic              ovf;
    logic [39:0]       bcd;
    longint unsigned   m;
    longint unsigned   lim;
    neg = s & b[31];
    m   = neg ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (m >= lim);
    bcd = '0;
    for (int i = 0; i < nd; i++) begin
      bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {neg, ovf, bcd};
  endfunction

  function automatic logic [41:0] cur(input bit sel);
    return sel ? {neg_b, ovf_b, 16'h0, bcd_b} : {neg_a, ovf_a, bcd_a};
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  task automatic pulse_start(input bit sel, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    bin = b;
    sgn = s;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    exp_q.push_back(model(b, s, sel ? 6 : 10));
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Called #1 after the accepting edge; lat counts edges from that edge to Done_o
  task automatic wait_result(input bit sel, output int lat, output int busy_n,
                             output bit stable, output logic [41:0] got);
    logic [41:0] held;
    held   = cur(sel);
    stable = 1'b1;
    lat    = 0;
    @(negedge clk);
    busy_n = busy_of(sel) ? 1 : 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done_of(sel)) break;
      if (busy_of(sel)) busy_n++;
      if (cur(sel) !== held) stable = 1'b0;
      if (lat >= 200) break;
    end
    got = cur(sel);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, cur(0), state_a} !== '0) begin
      failures++;
      $display("FAIL reset_a got busy=%b done=%b res=%h state=%0d exp all 0",
               busy_a, done_a, cur(0), state_a);
    end
    checks++;
    if ({busy_b, done_b, cur(1), state_b} !== '0) begin
      failures++;
      $display("FAIL reset_b got busy=%b done=%b res=%h state=%0d exp all 0",
               busy_b, done_b, cur(1), state_b);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_zero_latency();
    int lat, busy_n;
    bit stable;
    logic [41:0] got, exp;
    pulse_start(0, 32'd0, 1'b0);
    wait_result(0, lat, busy_n, stable, got);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 34) begin failures++; $display("FAIL zero_latency got %0d exp 34", lat); end
    checks++;
    if (busy_n !== 34) begin failures++; $display("FAIL zero_busy_cycles got %0d exp 34", busy_n); end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL zero_result got %h exp %h", got, exp); end
  endtask

  task automatic test_conversions();
    logic [31:0] vals[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_F63C, 32'h8000_0000, 32'h0};
    logic        sg[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int lat, busy_n;
    bit stable;
    logic [41:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      pulse_start(0, vals[i], sg[i]);
      wait_result(0, lat, busy_n, stable, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL conv_%0d bin=%h s=%b got %h exp %h", i, vals[i], sg[i], got, exp);
      end
      checks++;
      if (!stable || lat !== 34) begin
        failures++;
        $display("FAIL conv_hold_%0d lat=%0d stable=%b exp 34/1", i, lat, stable);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vals[3] = '{32'd1234567, 32'd999999, 32'd1000000};
    int lat, busy_n;
    bit stable;
    logic [41:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      pulse_start(1, vals[i], 1'b0);
      wait_result(1, lat, busy_n, stable, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat !== 34) begin
        failures++;
        $display("FAIL ovf_%0d bin=%0d got %h lat=%0d exp %h lat=34", i, vals[i], got, lat, exp);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int lat, busy_n;
    bit stable;
    logic [41:0] got, exp;
    pulse_start(0, 32'd100000, 1'b0);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      start_a = (lat == 3 || lat == 20);
      if (start_a) bin = 32'd5;
      @(negedge clk);
      if (done_a || lat >= 200) break;
    end
    got = cur(0);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 34 || got !== exp) begin
      failures++;
      $display("FAIL ignore_start got %h lat=%0d exp %h lat=34", got, lat, exp);
    end
    // Start held in the Done_o cycle must be accepted on the next edge
    bin = 32'd4321;
    sgn = 1'b1;
    start_a = 1'b1;
    exp_q.push_back(model(32'd4321, 1'b1, 10));
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_result(0, lat, busy_n, stable, got);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 34 || got !== exp) begin
      failures++;
      $display("FAIL back_to_back got %h lat=%0d exp %h lat=34", got, lat, exp);
    end
    // No stray conversion from the ignored starts
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL no_stray_busy got %b exp 0", busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n, dones;
    bit stable;
    logic [41:0] got, exp;
    @(posedge clk); #1;
    bin = 32'd123;
    sgn = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, cur(0), state_a} !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b res=%h state=%0d exp all 0",
               busy_a, done_a, cur(0), state_a);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL reset_no_done got %0d exp 0", dones); end
    pulse_start(0, 32'd123, 1'b0);
    wait_result(0, lat, busy_n, stable, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 42'h00_0000_0123) begin
      failures++;
      $display("FAIL after_reset got %h exp %h", got, exp);
    end
  endtask

  task automatic test_random();
    int lat, busy_n;
    bit stable;
    bit sel;
    logic [31:0] b;
    logic [41:0] got, exp;
    for (int i = 0; i < 10; i++) begin
      sel = (i >= 7);
      b   = sel ? 32'($urandom_range(0, 2000000)) : $urandom;
      pulse_start(sel, b, sel ? 1'b0 : 1'($urandom_range(0, 1)));
      wait_result(sel, lat, busy_n, stable, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || lat !== 34) begin
        failures++;
        $display("FAIL random_%0d bin=%h got %h lat=%0d exp %h", i, b, got, lat, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bin = '0;
    sgn = 1'b0;
    test_reset();
    test_zero_latency();
    test_conversions();
    test_overflow();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
